alarm_seq_ctrl: RTL and testbench

- Timing/sequencing controller for the car-alarm function: turns the remote key and intrusion sensor into arm/disarm, exit delay, entry delay and a bounded siren burst.
- Drives the siren, the armed indicator and a short chirp for user feedback.
- Sits between the debounced remote/sensor inputs and the siren/LED drivers.
- Single clock domain.

---
 rtl/alarm_pkg.sv | 28 ++
 rtl/alarm_timer.sv | 33 +++
 rtl/alarm_seq_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_alarm_seq_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alarm_pkg.sv
// Shared definitions for the car-alarm sequencer: state encodings, default
// delay lengths and the counter-width helpers.
package alarm_pkg;

  typedef enum logic [2:0] {
    ST_DISARMED = 3'd0,
    ST_ARMING   = 3'd1,
    ST_ARMED    = 3'd2,
    ST_ENTRY    = 3'd3,
    ST_ALARM    = 3'd4
  } alarm_state_e;

  localparam int DEF_EXIT_CYCLES  = 8;
  localparam int DEF_ENTRY_CYCLES = 6;
  localparam int DEF_SIREN_CYCLES = 20;
  localparam int DEF_CHIRP_CYCLES = 2;
  localparam int DEF_PULSE_HALF   = 4;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // A counter that must hold N-1 needs clog2(N) bits, never fewer than one.
  function automatic int cnt_width(input int n);
    return max_of(1, $clog2(n));
  endfunction

endpackage

// File: rtl/alarm_timer.sv
// Loadable down-counter that parks at zero; zero_o flags the parked/expired count.
module alarm_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/alarm_seq_ctrl.sv
// Car-alarm sequencer: arm/disarm by remote press, exit/entry delays, bounded siren.
// Define ALARM_PULSE_EN to make the siren toggle every PULSE_HALF clocks in ALARM.
module alarm_seq_ctrl
  import alarm_pkg::*;
#(
  parameter int EXIT_CYCLES  = DEF_EXIT_CYCLES,
  parameter int ENTRY_CYCLES = DEF_ENTRY_CYCLES,
  parameter int SIREN_CYCLES = DEF_SIREN_CYCLES,
  parameter int CHIRP_CYCLES = DEF_CHIRP_CYCLES
`ifdef ALARM_PULSE_EN
  ,
  parameter int PULSE_HALF   = DEF_PULSE_HALF
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       remote,
  input  logic       sensor,
  output logic       alarm,
  output logic       armed,
  output logic       chirp,
  output logic [2:0] state_o
);

  localparam int TW = cnt_width(max_of(EXIT_CYCLES, max_of(ENTRY_CYCLES, SIREN_CYCLES)));
  localparam int CW = cnt_width(CHIRP_CYCLES);

  localparam logic [TW-1:0] EXIT_LD  = TW'(EXIT_CYCLES - 1);
  localparam logic [TW-1:0] ENTRY_LD = TW'(ENTRY_CYCLES - 1);
  localparam logic [TW-1:0] SIREN_LD = TW'(SIREN_CYCLES - 1);
  localparam logic [CW-1:0] CHIRP_LD = CW'(CHIRP_CYCLES - 1);

  alarm_state_e  state_q, state_d;
  logic          remote_q;
  logic          press;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;
  logic          chirp_start;
  logic          chirp_zero;
  logic          alarm_q, alarm_d;
  logic          armed_q, armed_d;
  logic          chirp_q, chirp_d;

`ifdef ALARM_PULSE_EN
  localparam int PW = cnt_width(PULSE_HALF);
  localparam logic [PW-1:0] PHASE_LAST = PW'(PULSE_HALF - 1);
  logic [PW-1:0] phase_q, phase_d;
`endif

  // remote_q follows remote even during reset so a key held through reset
  // release is not mistaken for a fresh press.
  assign press = remote & ~remote_q;

  always_comb begin
    state_d     = state_q;
    chirp_start = 1'b0;
    case (state_q)
      ST_DISARMED: begin
        if (press) begin
          state_d     = ST_ARMING;
          chirp_start = 1'b1;
        end
      end
      ST_ARMING: begin
        if (press) begin
          state_d     = ST_DISARMED;
          chirp_start = 1'b1;
        end else if (tmr_zero) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (press) begin
          state_d     = ST_DISARMED;
          chirp_start = 1'b1;
        end else if (sensor) begin
          state_d = ST_ENTRY;
        end
      end
      ST_ENTRY: begin
        if (press) begin
          state_d     = ST_DISARMED;
          chirp_start = 1'b1;
        end else if (tmr_zero) begin
          state_d = ST_ALARM;
        end
      end
      ST_ALARM: begin
        if (press) begin
          state_d     = ST_DISARMED;
          chirp_start = 1'b1;
        end else if (tmr_zero) begin
          state_d = ST_ARMED;
        end
      end
      default: state_d = ST_DISARMED;
    endcase
  end

  // Reload the shared timer on every state change; untimed states get zero.
  always_comb begin
    tmr_load = (state_d != state_q);
    case (state_d)
      ST_ARMING: tmr_val = EXIT_LD;
      ST_ENTRY:  tmr_val = ENTRY_LD;
      ST_ALARM:  tmr_val = SIREN_LD;
      default:   tmr_val = '0;
    endcase
  end

  always_comb begin
    armed_d = (state_d == ST_ARMED) || (state_d == ST_ENTRY) || (state_d == ST_ALARM);
    chirp_d = chirp_q;
    if (chirp_start) begin
      chirp_d = 1'b1;
    end else if (chirp_q && chirp_zero) begin
      chirp_d = 1'b0;
    end
`ifdef ALARM_PULSE_EN
    alarm_d = 1'b0;
    phase_d = '0;
    if (state_d == ST_ALARM) begin
      if (state_q != ST_ALARM) begin
        alarm_d = 1'b1;
      end else if (phase_q == PHASE_LAST) begin
        alarm_d = ~alarm_q;
      end else begin
        alarm_d = alarm_q;
        phase_d = phase_q + PW'(1);
      end
    end
`else
    alarm_d = (state_d == ST_ALARM);
`endif
  end

  always_ff @(posedge clk) begin
    remote_q <= remote;
    if (rst) begin
      state_q <= ST_DISARMED;
      alarm_q <= 1'b0;
      armed_q <= 1'b0;
      chirp_q <= 1'b0;
`ifdef ALARM_PULSE_EN
      phase_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      alarm_q <= alarm_d;
      armed_q <= armed_d;
      chirp_q <= chirp_d;
`ifdef ALARM_PULSE_EN
      phase_q <= phase_d;
`endif
    end
  end

  alarm_timer #(.W(TW)) u_main_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero_o   (tmr_zero)
  );

  alarm_timer #(.W(CW)) u_chirp_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (chirp_start),
    .load_val (CHIRP_LD),
    .zero_o   (chirp_zero)
  );

  assign alarm   = alarm_q;
  assign armed   = armed_q;
  assign chirp   = chirp_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_alarm_seq_ctrl.sv
// Bench for alarm_seq_ctrl: directed scenarios then random remote/sensor/reset
// traffic, compared every cycle against a time-since-entry model (ALARM_PULSE_EN aware).
module tb_alarm_seq_ctrl;

  localparam int EXIT_N  = 8;
  localparam int ENTRY_N = 6;
  localparam int SIREN_N = 20;
  localparam int CHIRP_N = 2;
  localparam int HALF_N  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       remote = 1'b1;
  logic       sensor = 1'b1;
  logic       alarm, armed, chirp;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  alarm_seq_ctrl #(
    .EXIT_CYCLES  (EXIT_N),
    .ENTRY_CYCLES (ENTRY_N),
    .SIREN_CYCLES (SIREN_N),
    .CHIRP_CYCLES (CHIRP_N)
`ifdef ALARM_PULSE_EN
    ,
    .PULSE_HALF   (HALF_N)
`endif
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .remote  (remote),
    .sensor  (sensor),
    .alarm   (alarm),
    .armed   (armed),
    .chirp   (chirp),
    .state_o (state_o)
  );

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // m_state: 0 disarmed, 1 arming, 2 armed, 3 entry, 4 alarm.
  // m_elapsed: clocks spent in the current state, 1 on the entry edge.
  int   m_state = 0;
  int   m_elapsed = 0;
  int   m_chirp_left = 0;
  logic m_prev_remote = 1'b0;
  logic [5:0] exp_q[$];

  function automatic logic model_alarm();
    if (m_state != 4) return 1'b0;
`ifdef ALARM_PULSE_EN
    return (((m_elapsed - 1) / HALF_N) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic model_step();
    logic p;
    int   nxt;
    if (rst) begin
      m_state = 0;
      m_elapsed = 0;
      m_chirp_left = 0;
      m_prev_remote = remote;
      return;
    end
    p = remote && !m_prev_remote;
    m_prev_remote = remote;
    nxt = m_state;
    if (p) begin
      nxt = (m_state == 0) ? 1 : 0;
      m_chirp_left = CHIRP_N;
    end else begin
      if (m_chirp_left > 0) m_chirp_left--;
      if (m_state == 1 && m_elapsed == EXIT_N)  nxt = 2;
      if (m_state == 2 && sensor)               nxt = 3;
      if (m_state == 3 && m_elapsed == ENTRY_N) nxt = 4;
      if (m_state == 4 && m_elapsed == SIREN_N) nxt = 2;
    end
    if (nxt != m_state) m_elapsed = 1;
    else m_elapsed++;
    m_state = nxt;
  endtask

  // ---------------- scoreboard ----------------
  always @(posedge clk) begin
    logic [5:0] e;
    model_step();
    exp_q.push_back({3'(m_state), model_alarm(), (m_state >= 2), (m_chirp_left > 0)});
    #1;
    e = exp_q.pop_front();
    check_eq("state_o", 8'(state_o), 8'(e[5:3]));
    check_eq("alarm",   8'(alarm),   8'(e[2]));
    check_eq("armed",   8'(armed),   8'(e[1]));
    check_eq("chirp",   8'(chirp),   8'(e[0]));
  end

  // ---------------- driver tasks ----------------
  task automatic cycle(input logic r, input logic s);
    @(negedge clk);
    remote = r;
    sensor = s;
  endtask

  task automatic wait_model(input int st, input int el, input int budget);
    int n = 0;
    while (!(m_state == st && m_elapsed == el) && n < budget) begin
      cycle(1'b0, 1'b0);
      n++;
    end
    if (n >= budget) begin
      checks++;
      errors++;
      $display("FAIL wait_model: state %0d elapsed %0d never reached (got %0d/%0d)",
               st, el, m_state, m_elapsed);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset with key and sensor active, then release with key still held.
    repeat (2) cycle(1'b1, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) cycle(1'b1, 1'b0);
    repeat (2) cycle(1'b0, 1'b0);

    // Arm with sensor pulses during the exit delay.
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    cycle(1'b0, 1'b1);
    wait_model(2, 1, 20);

    // Trip, then disarm in the fifth siren clock.
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    wait_model(4, 4, 40);
    cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);

    // Full siren burst with sensor held high across re-arm.
    cycle(1'b1, 1'b0);
    wait_model(2, 1, 20);
    repeat (30) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    wait_model(2, 2, 60);

    // Press on the same edge ENTRY expires.
    cycle(1'b0, 1'b1);
    wait_model(3, ENTRY_N - 1, 20);
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);

    // Key held 50 clocks is one press.
    repeat (50) cycle(1'b1, 1'b0);
    repeat (3) cycle(1'b0, 1'b0);

    // Reset in the middle of the siren.
    cycle(1'b0, 1'b1);
    wait_model(4, 7, 40);
    @(negedge clk);
    rst = 1'b1;
    sensor = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 29) == 0) remote = ~remote;
      sensor = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 999) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
